// File: rtl/dcache_victim_buffer.sv
// dcache_victim_buffer: fully-associative victim buffer beside the write-back dcache.
// Ports: lookup_valid_i/lookup_addr_i -> v_hit_o/v_rdata_o/v_rdirty_o (combinational lookup);
// v_take_i invalidates the hit entry; v_wr_* inserts an evicted line (v_ready_o, v_overflow_o);
// v_flush_i drains dirty entries then invalidates all (v_flush_done_o);
// victim2mem_req_o/addr_o/data_o with mem2victim_ack_i carry writebacks to data memory.
// Optional: define VICTIM_STATS_EN to add saturating stat_hits_o/stat_lookups_o/stat_wbacks_o.
module dcache_victim_buffer #(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_W      = 32,
    parameter int OFFSET_W    = 4,
    parameter int LINE_W      = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              v_hit_o,
    output logic [LINE_W-1:0] v_rdata_o,
    output logic              v_rdirty_o,
    input  logic              v_take_i,
    input  logic              v_wr_en_i,
    input  logic [ADDR_W-1:0] v_wr_addr_i,
    input  logic [LINE_W-1:0] v_wr_data_i,
    input  logic              v_wr_dirty_i,
    output logic              v_ready_o,
    output logic              v_overflow_o,
    input  logic              v_flush_i,
    output logic              v_flush_done_o,
    output logic              victim2mem_req_o,
    output logic [ADDR_W-1:0] victim2mem_addr_o,
    output logic [LINE_W-1:0] victim2mem_data_o,
    input  logic              mem2victim_ack_i
`ifdef VICTIM_STATS_EN
    ,
    output logic [31:0]       stat_hits_o,
    output logic [31:0]       stat_lookups_o,
    output logic [31:0]       stat_wbacks_o
`endif
);
    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_FLUSH} wb_state_t;
    wb_state_t state;
    logic [NUM_ENTRIES-1:0] valid, dirty, take_vec;
    logic [TAG_W-1:0] tag [NUM_ENTRIES];
    logic [LINE_W-1:0] data [NUM_ENTRIES];
    logic [PTR_W-1:0] ptr, hit_idx, free_idx, match_idx, ins_idx, scan_idx;
    logic [PTR_W:0] scan;
    logic [TAG_W-1:0] lk_tag, wr_tag, wb_tag;
    logic [LINE_W-1:0] wb_data;
    logic ent_hit, wb_hit, any_free, wr_present, displace, ins, flush_pend;
    logic unused_offset_bits;
    assign lk_tag = lookup_addr_i[ADDR_W-1:OFFSET_W];
    assign wr_tag = v_wr_addr_i[ADDR_W-1:OFFSET_W];
    assign scan_idx = scan[PTR_W-1:0];
    assign unused_offset_bits = ^{lookup_addr_i[OFFSET_W-1:0], v_wr_addr_i[OFFSET_W-1:0]};
    // Descending loops so the lowest matching index is the one left standing.
    always_comb begin
        ent_hit = 1'b0;
        hit_idx = '0;
        wr_present = 1'b0;
        match_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == lk_tag) begin
                ent_hit = 1'b1;
                hit_idx = PTR_W'(i);
            end
            if (valid[i] && tag[i] == wr_tag) begin
                wr_present = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
        wb_hit = victim2mem_req_o && wb_tag == lk_tag;
        v_hit_o = lookup_valid_i && (ent_hit || wb_hit);
        take_vec = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            take_vec[i] = v_take_i && lookup_valid_i && ent_hit && hit_idx == PTR_W'(i);
            if (!valid[i] || take_vec[i]) begin
                any_free = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
        v_rdata_o = !v_hit_o ? '0 : ent_hit ? data[hit_idx] : wb_data;
        v_rdirty_o = v_hit_o && (ent_hit ? dirty[hit_idx] : 1'b1);
        v_ready_o = !(state != WB_IDLE && !any_free && dirty[ptr]) && state != WB_FLUSH;
        displace = !wr_present && !any_free;
        ins_idx = wr_present ? match_idx : any_free ? free_idx : ptr;
        ins = v_wr_en_i && v_ready_o;
    end
    assign victim2mem_addr_o = {wb_tag, {OFFSET_W{1'b0}}};
    assign victim2mem_data_o = wb_data;
    always_ff @(posedge clk) begin
        if (ins) begin
            tag[ins_idx]  <= wr_tag;
            data[ins_idx] <= v_wr_data_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid            <= '0;
            dirty            <= '0;
            ptr              <= '0;
            scan             <= '0;
            state            <= WB_IDLE;
            flush_pend       <= 1'b0;
            victim2mem_req_o <= 1'b0;
            wb_tag           <= '0;
            wb_data          <= '0;
            v_overflow_o     <= 1'b0;
            v_flush_done_o   <= 1'b0;
        end else begin
            v_overflow_o   <= v_wr_en_i && !v_ready_o;
            v_flush_done_o <= 1'b0;
            valid <= valid & ~take_vec;
            if (ins) begin
                valid[ins_idx] <= 1'b1;
                dirty[ins_idx] <= v_wr_dirty_i | (wr_present & dirty[ins_idx]);
                if (displace)
                    ptr <= ptr + 1'b1;
            end
            case (state)
                WB_IDLE: begin
                    // A dirty displacement claims the writeback register first; a
                    // simultaneous flush waits for its ack.
                    if (ins && displace && dirty[ptr]) begin
                        victim2mem_req_o <= 1'b1;
                        wb_tag           <= tag[ptr];
                        wb_data          <= data[ptr];
                        flush_pend       <= v_flush_i;
                        state            <= WB_REQ;
                    end else if (v_flush_i) begin
                        scan  <= '0;
                        state <= WB_FLUSH;
                    end
                end
                WB_REQ: begin
                    if (v_flush_i)
                        flush_pend <= 1'b1;
                    if (mem2victim_ack_i) begin
                        victim2mem_req_o <= 1'b0;
                        flush_pend       <= 1'b0;
                        scan             <= '0;
                        state            <= (flush_pend || v_flush_i) ? WB_FLUSH : WB_IDLE;
                    end
                end
                WB_FLUSH: begin
                    if (victim2mem_req_o) begin
                        if (mem2victim_ack_i) begin
                            victim2mem_req_o <= 1'b0;
                            scan             <= scan + 1'b1;
                        end
                    end else if (scan == (PTR_W + 1)'(NUM_ENTRIES)) begin
                        valid          <= '0;
                        dirty          <= '0;
                        v_flush_done_o <= 1'b1;
                        state          <= WB_IDLE;
                    end else if (valid[scan_idx] && dirty[scan_idx]) begin
                        victim2mem_req_o <= 1'b1;
                        wb_tag           <= tag[scan_idx];
                        wb_data          <= data[scan_idx];
                    end else begin
                        scan <= scan + 1'b1;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end
`ifdef VICTIM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits_o    <= '0;
            stat_lookups_o <= '0;
            stat_wbacks_o  <= '0;
        end else begin
            if (v_hit_o && !(&stat_hits_o))
                stat_hits_o <= stat_hits_o + 1'b1;
            if (lookup_valid_i && !(&stat_lookups_o))
                stat_lookups_o <= stat_lookups_o + 1'b1;
            if (victim2mem_req_o && mem2victim_ack_i && !(&stat_wbacks_o))
                stat_wbacks_o <= stat_wbacks_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_victim_buffer.sv
// tb_dcache_victim_buffer: scoreboard bench for dcache_victim_buffer (N=4, 32-bit addr, 128-bit lines).
module tb_dcache_victim_buffer;
    localparam int N = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic lookup_valid_i = 1'b0, v_take_i = 1'b0, v_wr_en_i = 1'b0, v_wr_dirty_i = 1'b0;
    logic v_flush_i = 1'b0, mem2victim_ack_i = 1'b0;
    logic [31:0] lookup_addr_i = '0, v_wr_addr_i = '0;
    logic [127:0] v_wr_data_i = '0;
    logic v_hit_o, v_rdirty_o, v_ready_o, v_overflow_o, v_flush_done_o, victim2mem_req_o;
    logic [127:0] v_rdata_o, victim2mem_data_o;
    logic [31:0] victim2mem_addr_o;
`ifdef VICTIM_STATS_EN
    logic [31:0] stat_hits_o, stat_lookups_o, stat_wbacks_o;
`endif
    int checks = 0, errors = 0;

    typedef struct packed {logic hit; logic dirty; logic [127:0] data;} lk_t;
    typedef struct packed {logic [31:0] addr; logic [127:0] data;} wb_t;
    lk_t lk_q[$];
    wb_t wb_q[$];

    dcache_victim_buffer #(.NUM_ENTRIES(N), .ADDR_W(32), .OFFSET_W(4), .LINE_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
        .v_hit_o(v_hit_o), .v_rdata_o(v_rdata_o), .v_rdirty_o(v_rdirty_o),
        .v_take_i(v_take_i), .v_wr_en_i(v_wr_en_i), .v_wr_addr_i(v_wr_addr_i),
        .v_wr_data_i(v_wr_data_i), .v_wr_dirty_i(v_wr_dirty_i),
        .v_ready_o(v_ready_o), .v_overflow_o(v_overflow_o),
        .v_flush_i(v_flush_i), .v_flush_done_o(v_flush_done_o),
        .victim2mem_req_o(victim2mem_req_o), .victim2mem_addr_o(victim2mem_addr_o),
        .victim2mem_data_o(victim2mem_data_o), .mem2victim_ack_i(mem2victim_ack_i)
`ifdef VICTIM_STATS_EN
        , .stat_hits_o(stat_hits_o), .stat_lookups_o(stat_lookups_o), .stat_wbacks_o(stat_wbacks_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5a5a_a5a5, a + 32'h1234_5678};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {lookup_valid_i, v_take_i, v_wr_en_i, v_wr_dirty_i, v_flush_i, mem2victim_ack_i} = '0;
        lk_q.delete();
        wb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic insert(input logic [31:0] a, input logic d);
        v_wr_en_i = 1'b1;
        v_wr_addr_i = a;
        v_wr_data_i = mk(a);
        v_wr_dirty_i = d;
        tick();
        v_wr_en_i = 1'b0;
    endtask

    task automatic pop_lookup(input string tag);
        lk_t e;
        #1;
        if (lk_q.size() == 0) begin
            check({tag, "_noexp"}, 1, 0);
            return;
        end
        e = lk_q.pop_front();
        check({tag, "_hit"}, v_hit_o, e.hit);
        check({tag, "_dirty"}, v_rdirty_o, e.dirty);
        check({tag, "_data"}, v_rdata_o, e.data);
    endtask

    task automatic lookup(input string tag, input logic [31:0] a, input logic h, input logic d,
                          input logic [127:0] dat);
        lookup_valid_i = 1'b1;
        lookup_addr_i = a;
        lk_q.push_back('{h, d, dat});
        pop_lookup(tag);
        lookup_valid_i = 1'b0;
    endtask

    task automatic serve_wb(input string tag, input int delay);
        wb_t e;
        int n = 0;
        while (!victim2mem_req_o && n < 50) begin
            tick();
            n++;
        end
        if (!victim2mem_req_o) begin
            check({tag, "_req_timeout"}, 0, 1);
            return;
        end
        if (wb_q.size() == 0) begin
            check({tag, "_unexpected_req"}, 1, 0);
            return;
        end
        e = wb_q.pop_front();
        check({tag, "_addr"}, victim2mem_addr_o, e.addr);
        check({tag, "_data"}, victim2mem_data_o, e.data);
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, "_req_held"}, victim2mem_req_o, 1);
            check({tag, "_addr_held"}, victim2mem_addr_o, e.addr);
        end
        mem2victim_ack_i = 1'b1;
        tick();
        mem2victim_ack_i = 1'b0;
        check({tag, "_req_drop"}, victim2mem_req_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        do_reset();
        check("rst_ready", v_ready_o, 1);
        check("rst_req", victim2mem_req_o, 0);
        check("rst_ovf", v_overflow_o, 0);
        check("rst_done", v_flush_done_o, 0);
        check("rst_wb_addr", victim2mem_addr_o, 0);
        lookup("rst_lk", 32'h1000, 0, 0, 0);

        insert(32'h1000, 0);
        lookup("basic", 32'h1004, 1, 0, mk(32'h1000));
        lookup("basic_miss", 32'h2000, 0, 0, 0);

        do_reset();
        for (int i = 0; i <= N; i++) begin
            insert(32'(i) * 32'h100, 0);
            check("clean_no_req", victim2mem_req_o, 0);
        end
        lookup("fifo_evicted", 32'h000, 0, 0, 0);
        lookup("fifo_new", 32'h400, 1, 0, mk(32'h400));
        lookup("fifo_keep", 32'h100, 1, 0, mk(32'h100));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clean_no_req_late", victim2mem_req_o, 0);
        end

        do_reset();
        insert(32'h00c, 1);
        for (int i = 1; i < N; i++) insert(32'(i) * 32'h100, 1);
        check("full_ready", v_ready_o, 1);
        wb_q.push_back('{32'h000, mk(32'h00c)});
        insert(32'h400, 1);
        check("busy_req", victim2mem_req_o, 1);
        check("busy_ready", v_ready_o, 0);
        lookup("wbreg_hit", 32'h000, 1, 1, mk(32'h00c));
        v_wr_en_i = 1'b1;
        v_wr_addr_i = 32'h500;
        v_wr_data_i = mk(32'h500);
        v_wr_dirty_i = 1'b1;
        tick();
        v_wr_en_i = 1'b0;
        check("ovf_pulse", v_overflow_o, 1);
        tick();
        check("ovf_clear", v_overflow_o, 0);
        lookup("ovf_drop", 32'h500, 0, 0, 0);
        lookup("ovf_keep", 32'h100, 1, 1, mk(32'h100));
        serve_wb("wb1", 7);
        check("idle_ready", v_ready_o, 1);
        lookup("wb_done_miss", 32'h000, 0, 0, 0);
        lookup("wb_new", 32'h400, 1, 1, mk(32'h400));

        do_reset();
        insert(32'h000, 0);
        insert(32'h100, 0);
        insert(32'h200, 0);
        insert(32'h400, 0);
        lookup_valid_i = 1'b1;
        lookup_addr_i = 32'h200;
        v_take_i = 1'b1;
        v_wr_en_i = 1'b1;
        v_wr_addr_i = 32'h300;
        v_wr_data_i = mk(32'h300);
        v_wr_dirty_i = 1'b0;
        lk_q.push_back('{1'b1, 1'b0, mk(32'h200)});
        pop_lookup("take_hit");
        check("take_ready", v_ready_o, 1);
        tick();
        {lookup_valid_i, v_take_i, v_wr_en_i} = '0;
        lookup("take_gone", 32'h200, 0, 0, 0);
        lookup("take_fill", 32'h300, 1, 0, mk(32'h300));
        lookup("take_keep0", 32'h000, 1, 0, mk(32'h000));
        check("take_no_req", victim2mem_req_o, 0);

        do_reset();
        insert(32'h100, 1);
        insert(32'h200, 0);
        insert(32'h300, 1);
        insert(32'h400, 0);
        wb_q.push_back('{32'h100, mk(32'h100)});
        wb_q.push_back('{32'h300, mk(32'h300)});
        v_flush_i = 1'b1;
        tick();
        v_flush_i = 1'b0;
        check("flush_ready", v_ready_o, 0);
        serve_wb("fl1", 2);
        serve_wb("fl2", 3);
        cnt = 0;
        while (!v_flush_done_o && cnt < 20) begin
            check("flush_no_extra_req", victim2mem_req_o, 0);
            tick();
            cnt++;
        end
        check("flush_done", v_flush_done_o, 1);
        check("flush_q_empty", 32'(wb_q.size()), 0);
        tick();
        check("flush_done_pulse", v_flush_done_o, 0);
        for (int i = 1; i <= N; i++)
            lookup("flush_miss", 32'(i) * 32'h100, 0, 0, 0);

        do_reset();
        insert(32'h000, 0);
        v_flush_i = 1'b1;
        tick();
        v_flush_i = 1'b0;
        cnt = 0;
        while (!v_flush_done_o && cnt < 20) begin
            tick();
            cnt++;
        end
        check("clean_flush_cycles", 32'(cnt), 32'(N + 1));
        check("clean_flush_no_req", victim2mem_req_o, 0);
        lookup("clean_flush_miss", 32'h000, 0, 0, 0);

        do_reset();
        mem2victim_ack_i = 1'b1;
        tick();
        mem2victim_ack_i = 1'b0;
        check("idle_ack_req", victim2mem_req_o, 0);
        check("idle_ack_ready", v_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
